// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - UART 8N1 receiver with a valid/ready holding register
// Flags framing errors (stop bit low) and overruns (byte lost while the holding register is full).
module uart_cmd_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  localparam logic [9:0] LP_BIT_LAST  = 10'(CLKS_PER_BIT - 1);
  localparam logic [9:0] LP_HALF_LAST = 10'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t     r_state;
  logic       r_sync1;
  logic       r_sync2;
  logic [9:0] r_cnt;
  logic [2:0] r_bit_idx;
  logic [7:0] r_shreg;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_frame_err;
  logic       r_overrun;
  logic       r_busy;
  logic       w_rx_s;

  assign w_rx_s    = r_sync2;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = r_busy;

  // Synchronizer resets to the idle line level so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 10'd0;
      r_bit_idx   <= 3'd0;
      r_shreg     <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      // A delivery later in this block overrides the clear on the same edge.
      if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_cnt <= 10'd0;
          if (!w_rx_s) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt == LP_HALF_LAST) begin
            r_cnt     <= 10'd0;
            r_bit_idx <= 3'd0;
            if (!w_rx_s) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
        end

        S_DATA: begin
          if (r_cnt == LP_BIT_LAST) begin
            r_cnt              <= 10'd0;
            r_shreg[r_bit_idx] <= w_rx_s;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
        end

        S_STOP: begin
          if (r_cnt == LP_BIT_LAST) begin
            r_cnt <= 10'd0;
            if (w_rx_s) begin
              if (!r_rx_valid || rx_ready) begin
                r_rx_data  <= r_shreg;
                r_rx_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
              // Leaving at the stop-bit centre lets a zero-gap start bit be caught.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
        end

        S_BREAK: begin
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - self-checking bench for uart_cmd_rx
// A frame-level model predicts delivery/error events; directed literal checks pin the model.
module tb_uart_cmd_rx;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 1_152_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;
  localparam int LAT      = HALF + 9 * CPB + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_cmd_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [7:0] d;
    bit         ferr;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] acc_log[$];

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         last_rise = 0;
  int         last_fall = 0;

  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       exp_fe = 1'b0;
  logic       exp_ov = 1'b0;
  logic       ready_s;
  logic       valid_s;
  logic [7:0] data_s;
  logic       prev_valid = 1'b0;
  logic       was_valid;
  logic       accept;
  ev_t        ev;

  // Model update and per-cycle compare, 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    cyc++;
    ready_s = rx_ready;
    valid_s = rx_valid;
    data_s  = rx_data;
    #1;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      evq.delete();
    end else begin
      was_valid = m_valid;
      accept    = m_valid && ready_s;
      if (accept) m_valid = 1'b0;
      if (evq.size() > 0 && evq[0].at == cyc) begin
        ev = evq.pop_front();
        if (ev.ferr) begin
          exp_fe = 1'b1;
        end else if (!was_valid || accept) begin
          m_valid = 1'b1;
          m_data  = ev.d;
        end else begin
          exp_ov = 1'b1;
        end
      end
      if (valid_s && ready_s) acc_log.push_back(data_s);
    end
    checks++;
    if (rx_valid !== m_valid || (m_valid && rx_data !== m_data) ||
        frame_err !== exp_fe || overrun !== exp_ov ||
        (rst && (busy !== 1'b0 || rx_data !== 8'h00))) begin
      errors++;
      $display("FAIL cycle_compare @%0d: got valid=%b data=%h fe=%b ov=%b busy=%b, want valid=%b data=%h fe=%b ov=%b",
               cyc, rx_valid, rx_data, frame_err, overrun, busy, m_valid, m_data, exp_fe, exp_ov);
    end
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (rx_valid && !prev_valid) last_rise = cyc;
    prev_valid = rx_valid;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge that ends the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    rxd       = 1'b0;
    last_fall = cyc;
    evq.push_back('{at: cyc + LAT, d: b, ferr: !stop_v});
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      rxd = b[i];
    end
    repeat (CPB) @(negedge clk);
    rxd = stop_v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!rx_valid && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(rx_valid), 1);
  endtask

  task automatic accept_one();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         ovr0;
    logic [7:0] b;

    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_valid", int'(rx_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_data", int'(rx_data), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // single byte, held until accepted
    send_frame(8'hA5, 1'b1);
    check("a5_latency", last_rise - last_fall, 820);
    check("a5_data", int'(rx_data), 8'hA5);
    repeat (50) @(negedge clk);
    check("a5_held_valid", int'(rx_valid), 1);
    check("a5_held_data", int'(rx_data), 8'hA5);
    accept_one();
    check("a5_accept", int'(rx_valid), 0);
    acc_log.delete();

    // start glitch shorter than half a bit
    repeat (CPB) @(negedge clk);
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_hi", int'(busy), 1);
    repeat (10) @(negedge clk);
    rxd = 1'b1;
    repeat (HALF + 2) @(negedge clk);
    check("glitch_busy_lo", int'(busy), 0);
    check("glitch_no_valid", int'(rx_valid), 0);
    check("glitch_no_ferr", ferr_cnt, 0);

    // framing error, held-low break, then a good byte
    repeat (CPB) @(negedge clk);
    send_frame(8'h3C, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    check("break_busy", int'(busy), 1);
    rxd = 1'b1;
    repeat (CPB) @(negedge clk);
    check("ferr_count", ferr_cnt, 1);
    check("ferr_no_valid", int'(rx_valid), 0);
    send_frame(8'h7E, 1'b1);
    wait_valid("7e_valid");
    check("7e_data", int'(rx_data), 8'h7E);
    accept_one();

    // back-to-back with the holding register full
    repeat (CPB) @(negedge clk);
    acc_log.delete();
    ovr0 = ovr_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("ovr_count", ovr_cnt - ovr0, 1);
    check("ovr_kept_data", int'(rx_data), 8'h11);
    check("ovr_kept_valid", int'(rx_valid), 1);
    accept_one();
    check("ovr_log_size", acc_log.size(), 1);
    check("ovr_log0", int'(acc_log[0]), 8'h11);

    // back-to-back with the consumer always ready
    repeat (CPB) @(negedge clk);
    acc_log.delete();
    ovr0 = ovr_cnt;
    rx_ready = 1'b1;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (CPB) @(negedge clk);
    rx_ready = 1'b0;
    check("rdy_log_size", acc_log.size(), 2);
    check("rdy_log0", int'(acc_log[0]), 8'h11);
    check("rdy_log1", int'(acc_log[1]), 8'h22);
    check("rdy_no_ovr", ovr_cnt - ovr0, 0);

    // three frames, zero idle gap
    acc_log.delete();
    ovr0 = ovr_cnt;
    rx_ready = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    repeat (CPB) @(negedge clk);
    rx_ready = 1'b0;
    check("gap0_log_size", acc_log.size(), 3);
    check("gap0_log0", int'(acc_log[0]), 8'h00);
    check("gap0_log1", int'(acc_log[1]), 8'hFF);
    check("gap0_log2", int'(acc_log[2]), 8'h55);
    check("gap0_no_ovr", ovr_cnt - ovr0, 0);
    check("gap0_no_ferr", ferr_cnt, 1);

    // reset in the middle of bit 4 of 0xC3, then a fresh byte
    repeat (CPB) @(negedge clk);
    b   = 8'hC3;
    rxd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (CPB) @(negedge clk);
      rxd = b[i];
    end
    repeat (CPB / 2) @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    check("in_reset_busy", int'(busy), 0);
    check("in_reset_valid", int'(rx_valid), 0);
    check("in_reset_ferr", int'(frame_err), 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check("post_reset_valid", int'(rx_valid), 0);
    check("post_reset_busy", int'(busy), 0);
    send_frame(8'h96, 1'b1);
    wait_valid("96_valid");
    check("96_data", int'(rx_data), 8'h96);
    accept_one();
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
